// File: rtl/iterative_multiplier.sv
// Iterative shift-add unsigned multiplier.
// One partial-product step per clock; a WIDTH x WIDTH product takes WIDTH CALC
// cycles, then a one-cycle DONE state before returning to IDLE.
module iterative_multiplier #(
    parameter int unsigned WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 c_q, c_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    // {C,Hi} after the conditional add, and {C,Hi,Lo} after the right shift
    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     shifted;

    // One shift-add step computed from the current accumulator
    always_comb begin
        sum     = lo_q[0] ? ({1'b0, hi_q} + {1'b0, mcand_q}) : {c_q, hi_q};
        shifted = {sum, lo_q} >> 1;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d = A;
                    lo_d    = B;
                    hi_d    = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                c_d   = shifted[2*WIDTH];
                hi_d  = shifted[2*WIDTH-1:WIDTH];
                lo_d  = shifted[WIDTH-1:0];
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    p_d     = shifted[2*WIDTH-1:0];
                    state_d = StDone;
                end
            end
            StDone: begin
                // start is deliberately ignored here
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Status outputs decoded straight from the state register
    always_comb begin
        busy = (state_q == StCalc);
        done = (state_q == StDone);
        P    = p_q;
    end

endmodule

// File: tb/tb_iterative_multiplier.sv
// Self-checking bench for iterative_multiplier (WIDTH = 6).
module tb_iterative_multiplier;

    localparam int W = 6;

    logic             clk;
    logic             reset;
    logic             start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [2*W-1:0]   P;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    iterative_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; sample k is taken 1 time unit after edge k (edge 0 = accept).
    // Returns observations only; callers compare against their own expectations.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy,
                         output logic [2*W-1:0] p_done, output int done_at,
                         output int done_cnt, output int busy_cnt, output bit p_stable);
        logic [2*W-1:0] p_prev;
        p_prev   = P;
        start    = 1'b1;
        A        = a;
        B        = b;
        done_at  = -1;
        done_cnt = 0;
        busy_cnt = 0;
        p_stable = 1'b1;
        p_done   = '0;
        tick();
        for (int k = 0; k <= W + 3; k++) begin
            if (k > 0) tick();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    p_done  = P;
                end
            end
            if (k < W && P !== p_prev) p_stable = 1'b0;
            if (k > W && P !== p_done) p_stable = 1'b0;
            // Drive for edge k+1: noise on start/A/B must not disturb the operation
            if (noisy && k <= W) begin
                start = 1'($urandom);
                A     = W'($urandom);
                B     = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        logic [2*W-1:0] p;
        int da, dc, bc;
        bit ps;
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #3;
        n_checks++;
        if (P !== '0) begin n_fail++; $display("FAIL reset_P got %0d expected 0", P); end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got busy=%b done=%b expected 0 0", busy, done);
        end
        tick();
        tick();
        reset = 1'b0;
        // First start after release must be accepted at the very next edge
        do_op(6'd3, 6'd5, 1'b0, p, da, dc, bc, ps);
        n_checks++;
        if (bc !== W) begin
            n_fail++;
            $display("FAIL first_start_busy got %0d busy cycles expected %0d", bc, W);
        end
        n_checks++;
        if (p !== 12'd15) begin n_fail++; $display("FAIL first_start_P got %0d expected 15", p); end
    endtask

    task automatic test_directed;
        logic [W-1:0]   ta [5] = '{6'd63, 6'd0, 6'd1, 6'd37, 6'd9};
        logic [W-1:0]   tb [5] = '{6'd63, 6'd45, 6'd1, 6'd1, 6'd0};
        logic [2*W-1:0] tp [5] = '{12'd3969, 12'd0, 12'd1, 12'd37, 12'd0};
        logic [2*W-1:0] p;
        int da, dc, bc;
        bit ps;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], 1'b0, p, da, dc, bc, ps);
            n_checks++;
            if (p !== tp[i]) begin
                n_fail++;
                $display("FAIL directed_P %0d*%0d got %0d expected %0d", ta[i], tb[i], p, tp[i]);
            end
            n_checks++;
            if (da !== W || dc !== 1 || bc !== W) begin
                n_fail++;
                $display("FAIL directed_timing %0d*%0d got done_at=%0d done_cnt=%0d busy=%0d expected %0d 1 %0d",
                         ta[i], tb[i], da, dc, bc, W, W);
            end
            n_checks++;
            if (!ps) begin n_fail++; $display("FAIL directed_P_hold %0d*%0d P moved outside DONE entry", ta[i], tb[i]); end
        end
    endtask

    task automatic test_busy_ignore;
        int bc;
        logic [2*W-1:0] p_at_done;
        bit extra;
        bc    = 0;
        extra = 1'b0;
        p_at_done = '0;
        start = 1'b1;
        A     = 6'd5;
        B     = 6'd9;
        tick();
        for (int k = 0; k <= W + 3; k++) begin
            if (k > 0) tick();
            if (busy) bc++;
            if (k == W) p_at_done = P;
            if (k == W) begin
                n_checks++;
                if (done !== 1'b1) begin n_fail++; $display("FAIL ignore_done got %b expected 1", done); end
            end
            if (k > W && (busy || done)) extra = 1'b1;
            // start stays high through CALC and DONE, dropped before IDLE samples it
            start = (k <= W) ? 1'b1 : 1'b0;
            A     = 6'd63;
            B     = 6'd63;
        end
        n_checks++;
        if (p_at_done !== 12'd45) begin n_fail++; $display("FAIL ignore_P got %0d expected 45", p_at_done); end
        n_checks++;
        if (bc !== W) begin n_fail++; $display("FAIL ignore_busy got %0d expected %0d", bc, W); end
        n_checks++;
        if (extra) begin n_fail++; $display("FAIL ignore_restart got busy/done after DONE expected idle"); end
    endtask

    task automatic test_back_to_back;
        int             done_k [$];
        logic [2*W-1:0] done_p [$];
        start = 1'b1;
        A     = 6'd12;
        B     = 6'd10;
        tick();
        A = 6'd7;
        B = 6'd3;
        for (int k = 1; k <= 2 * W + 6; k++) begin
            tick();
            if (done) begin
                done_k.push_back(k);
                done_p.push_back(P);
            end
            if (k == W + 2) start = 1'b0;
        end
        n_checks++;
        if (done_k.size() !== 2) begin
            n_fail++;
            $display("FAIL b2b_count got %0d done pulses expected 2", done_k.size());
        end else begin
            n_checks++;
            if (done_p[0] !== 12'd120 || done_p[1] !== 12'd21) begin
                n_fail++;
                $display("FAIL b2b_P got %0d,%0d expected 120,21", done_p[0], done_p[1]);
            end
            n_checks++;
            if (done_k[0] !== W || done_k[1] - done_k[0] !== W + 2) begin
                n_fail++;
                $display("FAIL b2b_spacing got first=%0d gap=%0d expected %0d %0d",
                         done_k[0], done_k[1] - done_k[0], W, W + 2);
            end
        end
    endtask

    task automatic test_reset_mid_op;
        logic [2*W-1:0] p;
        int da, dc, bc;
        bit ps;
        bit seen;
        start = 1'b1;
        A     = 6'd50;
        B     = 6'd50;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (P !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async got P=%0d busy=%b done=%b expected 0 0 0", P, busy, done);
        end
        tick();
        reset = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 2 * W + 4; k++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL midreset_no_done got activity after abort expected idle"); end
        do_op(6'd2, 6'd3, 1'b0, p, da, dc, bc, ps);
        n_checks++;
        if (p !== 12'd6 || da !== W) begin
            n_fail++;
            $display("FAIL midreset_restart got P=%0d done_at=%0d expected 6 %0d", p, da, W);
        end
    endtask

    task automatic test_exhaustive;
        logic [2*W-1:0] p, exp_p;
        int da, dc, bc;
        bit ps;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                exp_p = (2 * W)'(a * b);
                do_op(W'(a), W'(b), 1'b1, p, da, dc, bc, ps);
                n_checks++;
                if (p !== exp_p) begin
                    n_fail++;
                    $display("FAIL exh_P %0d*%0d got %0d expected %0d", a, b, p, exp_p);
                end
                n_checks++;
                if (da !== W || dc !== 1 || bc !== W) begin
                    n_fail++;
                    $display("FAIL exh_timing %0d*%0d got done_at=%0d done_cnt=%0d busy=%0d expected %0d 1 %0d",
                             a, b, da, dc, bc, W, W);
                end
                n_checks++;
                if (!ps) begin n_fail++; $display("FAIL exh_P_hold %0d*%0d P moved outside DONE entry", a, b); end
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic [2*W-1:0] p;
        int da, dc, bc;
        bit ps;
        for (int i = 0; i < 200; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            do_op(a, b, 1'b1, p, da, dc, bc, ps);
            n_checks++;
            if (p !== (2 * W)'(int'(a) * int'(b)) || da !== W) begin
                n_fail++;
                $display("FAIL rand %0d*%0d got P=%0d done_at=%0d expected %0d %0d",
                         a, b, p, da, int'(a) * int'(b), W);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();
        test_exhaustive();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
